// File: rtl/axi4_pkg.sv
// axi4_pkg: shared AXI4 widths, payload types, response codes and the
// memory-responder FSM state encodings.
package axi4_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_LEN_W  = 8;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  typedef logic [AXI_ADDR_W-1:0] axi_addr_t;
  typedef logic [AXI_DATA_W-1:0] axi_data_t;
  typedef logic [AXI_ID_W-1:0]   axi_id_t;
  typedef logic [AXI_LEN_W-1:0]  axi_len_t;
  typedef logic [AXI_STRB_W-1:0] axi_strb_t;
  typedef logic [1:0]            axi_resp_t;

  localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
  localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } axi4_mem_wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } axi4_mem_rstate_t;

  // Replace the strobed bytes of old_word with the matching bytes of new_word.
  function automatic axi_data_t axi_merge_bytes(input axi_data_t old_word,
                                                input axi_data_t new_word,
                                                input axi_strb_t strb);
    axi_data_t merged;
    merged = old_word;
    for (int b = 0; b < int'(AXI_STRB_W); b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_interface.sv
// axi_interface: AXI4 channel bundle (AW, W, B, AR, R) with master and
// slave modports. Only the fields used by word-granular INCR endpoints.
interface axi_interface;
  import axi4_pkg::*;

  axi_id_t   awid;
  axi_addr_t awaddr;
  axi_len_t  awlen;
  logic      awvalid;
  logic      awready;

  axi_data_t wdata;
  axi_strb_t wstrb;
  logic      wlast;
  logic      wvalid;
  logic      wready;

  axi_id_t   bid;
  axi_resp_t bresp;
  logic      bvalid;
  logic      bready;

  axi_id_t   arid;
  axi_addr_t araddr;
  axi_len_t  arlen;
  logic      arvalid;
  logic      arready;

  axi_id_t   rid;
  axi_data_t rdata;
  axi_resp_t rresp;
  logic      rlast;
  logic      rvalid;
  logic      rready;

  modport master (
    output awid, awaddr, awlen, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

endinterface

// File: rtl/axi4_mem_array.sv
// axi4_mem_array: DEPTH x axi_data_t storage, one byte-enabled synchronous
// write port and one asynchronous read port; synchronous reset clears all.
// Ports:
//   CLK, RST          clock, synchronous active-high clear
//   we, waddr, wstrb, wdata   write port (byte lanes gated by wstrb)
//   raddr, rdata_c    combinational read port (pre-write value in the
//                     cycle of a same-word write)
module axi4_mem_array
  import axi4_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  axi_strb_t        wstrb,
  input  axi_data_t        wdata,
  input  logic [IDX_W-1:0] raddr,
  output axi_data_t        rdata_c
);

  axi_data_t mem [DEPTH];

  // Storage update: full clear on reset, otherwise strobed byte write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= axi_merge_bytes(mem[waddr], wdata, wstrb);
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/axi4_mem_responder.sv
// axi4_mem_responder: AXI4 slave memory endpoint. Independent write
// (AW/W/B) and read (AR/R) FSMs over a word-addressed buffer; beat i of a
// burst targets addr+i, out-of-range beats answer SLVERR.
// Ports:
//   CLK   sole clock, posedge
//   RST   synchronous active-high reset; aborts bursts, clears the buffer
//   axi   axi_interface slave modport (AW, W, B, AR, R channels)
// Parameters:
//   DEPTH buffer words (valid word addresses 0..DEPTH-1)
//   ID    instance tag used in assertion messages
module axi4_mem_responder
  import axi4_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned ID    = 0
) (
  input logic         CLK,
  input logic         RST,
  axi_interface.slave axi
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic addr_in_range(input axi_addr_t a);
    return a < axi_addr_t'(DEPTH);
  endfunction

  // Write-side state
  axi4_mem_wstate_t w_state, w_state_d;
  axi_id_t          w_id, w_id_d;
  axi_addr_t        w_addr, w_addr_d;
  axi_len_t         w_len, w_len_d;
  axi_len_t         w_cnt, w_cnt_d;
  logic             w_err, w_err_d;
  logic             awready_q, awready_d;
  logic             wready_q, wready_d;
  logic             bvalid_q, bvalid_d;
  axi_id_t          bid_q, bid_d;
  axi_resp_t        bresp_q, bresp_d;
  logic             mem_we_c;

  // Read-side state
  axi4_mem_rstate_t r_state, r_state_d;
  axi_addr_t        r_addr, r_addr_d;
  axi_len_t         r_len, r_len_d;
  axi_len_t         r_cnt, r_cnt_d;
  logic             arready_q, arready_d;
  logic             rvalid_q, rvalid_d;
  logic             rlast_q, rlast_d;
  axi_id_t          rid_q, rid_d;
  axi_resp_t        rresp_q, rresp_d;
  axi_data_t        rdata_q, rdata_d;
  axi_addr_t        r_fetch_c;
  logic             r_load_c;
  axi_data_t        mem_rdata_c;
  axi_data_t        fetch_word_c;

  axi4_mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .CLK     (CLK),
    .RST     (RST),
    .we      (mem_we_c),
    .waddr   (w_addr[IDX_W-1:0]),
    .wstrb   (axi.wstrb),
    .wdata   (axi.wdata),
    .raddr   (r_fetch_c[IDX_W-1:0]),
    .rdata_c (mem_rdata_c)
  );

  // Write FSM: next state, burst bookkeeping and B channel.
  always_comb begin
    w_state_d = w_state;
    w_id_d    = w_id;
    w_addr_d  = w_addr;
    w_len_d   = w_len;
    w_cnt_d   = w_cnt;
    w_err_d   = w_err;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    mem_we_c  = 1'b0;

    unique case (w_state)
      W_IDLE: begin
        awready_d = 1'b1;
        if (axi.awvalid && awready_q) begin
          w_state_d = W_DATA;
          w_id_d    = axi.awid;
          w_addr_d  = axi.awaddr;
          w_len_d   = axi.awlen;
          w_cnt_d   = '0;
          w_err_d   = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
        end
      end
      W_DATA: begin
        if (axi.wvalid && wready_q) begin
          mem_we_c = addr_in_range(w_addr);
          // A misplaced wlast flags the burst but never shortens it.
          w_err_d  = w_err | ~addr_in_range(w_addr) | (axi.wlast != (w_cnt == w_len));
          if (w_cnt == w_len) begin
            w_state_d = W_RESP;
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bid_d     = w_id;
            bresp_d   = w_err_d ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          end else begin
            w_addr_d = w_addr + axi_addr_t'(1);
            w_cnt_d  = w_cnt + axi_len_t'(1);
          end
        end
      end
      W_RESP: begin
        if (axi.bready && bvalid_q) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM: next state, beat bookkeeping and which word to fetch next.
  always_comb begin
    r_state_d = r_state;
    r_addr_d  = r_addr;
    r_len_d   = r_len;
    r_cnt_d   = r_cnt;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    r_fetch_c = r_addr;
    r_load_c  = 1'b0;

    unique case (r_state)
      R_IDLE: begin
        arready_d = 1'b1;
        if (axi.arvalid && arready_q) begin
          r_state_d = R_DATA;
          r_len_d   = axi.arlen;
          r_cnt_d   = '0;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rlast_d   = (axi.arlen == '0);
          rid_d     = axi.arid;
          r_fetch_c = axi.araddr;
          r_load_c  = 1'b1;
        end
      end
      R_DATA: begin
        if (axi.rready && rvalid_q) begin
          if (r_cnt == r_len) begin
            r_state_d = R_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
          end else begin
            r_cnt_d   = r_cnt + axi_len_t'(1);
            rlast_d   = ((r_cnt + axi_len_t'(1)) == r_len);
            r_fetch_c = r_addr + axi_addr_t'(1);
            r_load_c  = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    if (r_load_c) r_addr_d = r_fetch_c;
  end

  // Next R payload. A write committing this edge to the fetched word is
  // forwarded so the beat presented next cycle already sees it; the beat
  // presented in the write's own cycle was captured earlier (pre-write).
  always_comb begin
    fetch_word_c = '0;
    if (addr_in_range(r_fetch_c)) fetch_word_c = mem_rdata_c;
    if (mem_we_c && (w_addr == r_fetch_c)) begin
      fetch_word_c = axi_merge_bytes(fetch_word_c, axi.wdata, axi.wstrb);
    end
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (r_load_c) begin
      rdata_d = fetch_word_c;
      rresp_d = addr_in_range(r_fetch_c) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_state   <= W_IDLE;
      w_id      <= '0;
      w_addr    <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_err     <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      r_state   <= R_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      w_state   <= w_state_d;
      w_id      <= w_id_d;
      w_addr    <= w_addr_d;
      w_len     <= w_len_d;
      w_cnt     <= w_cnt_d;
      w_err     <= w_err_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      r_state   <= r_state_d;
      r_addr    <= r_addr_d;
      r_len     <= r_len_d;
      r_cnt     <= r_cnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bid     = bid_q;
  assign axi.bresp   = bresp_q;
  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rlast   = rlast_q;
  assign axi.rid     = rid_q;
  assign axi.rresp   = rresp_q;
  assign axi.rdata   = rdata_q;

  // Beat counters must never pass the latched burst length.
  assert property (@(posedge CLK) disable iff (RST) (w_state != W_DATA) || (w_cnt <= w_len))
    else $error("axi4_mem_responder[%0d]: write beat counter overran burst length", ID);
  assert property (@(posedge CLK) disable iff (RST) (r_state != R_DATA) || (r_cnt <= r_len))
    else $error("axi4_mem_responder[%0d]: read beat counter overran burst length", ID);

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder: burst write/read, backpressure,
// strobes and range errors, concurrency, forwarding and mid-burst reset.
module tb_axi4_mem_responder;
  import axi4_pkg::*;

  localparam int unsigned DEPTH = 64;
  localparam axi_data_t   BASE  = 64'hdeadbeefdeadbeef;
  localparam axi_data_t   FULL  = 64'haaaaaaaaaaaaaaaa;
  localparam axi_data_t   PART  = 64'h0123456789abcdef;
  localparam axi_data_t   LDAT  = 64'h0000000000001234;
  localparam axi_data_t   WRAP  = 64'h5555000000000000;
  localparam axi_data_t   CONC  = 64'hc0c0c0c0c0c0c000;
  localparam axi_data_t   BYP   = 64'h0badf00d0badf00d;

  typedef struct {
    axi_addr_t addr;
    axi_data_t data;
    axi_resp_t resp;
  } rd_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  axi_interface axi_if ();

  axi4_mem_responder #(
    .DEPTH (DEPTH),
    .ID    (0)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .axi (axi_if)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".awready"}, 64'(axi_if.awready), 64'd0);
    check({tag, ".wready"},  64'(axi_if.wready),  64'd0);
    check({tag, ".bvalid"},  64'(axi_if.bvalid),  64'd0);
    check({tag, ".arready"}, 64'(axi_if.arready), 64'd0);
    check({tag, ".rvalid"},  64'(axi_if.rvalid),  64'd0);
    check({tag, ".rlast"},   64'(axi_if.rlast),   64'd0);
    check({tag, ".bresp"},   64'(axi_if.bresp),   64'd0);
    check({tag, ".rresp"},   64'(axi_if.rresp),   64'd0);
    check({tag, ".bid"},     64'(axi_if.bid),     64'd0);
    check({tag, ".rid"},     64'(axi_if.rid),     64'd0);
    check({tag, ".rdata"},   64'(axi_if.rdata),   64'd0);
  endtask

  task automatic do_aw(input axi_id_t id, input axi_addr_t addr, input axi_len_t len,
                       input string tag);
    int n = 0;
    axi_if.awid    = id;
    axi_if.awaddr  = addr;
    axi_if.awlen   = len;
    axi_if.awvalid = 1'b1;
    while (axi_if.awready !== 1'b1 && n < 32) begin
      cyc();
      n++;
    end
    if (n >= 32) check({tag, ".aw_timeout"}, 64'(axi_if.awready), 64'd1);
    cyc();
    axi_if.awvalid = 1'b0;
  endtask

  task automatic do_ar(input axi_id_t id, input axi_addr_t addr, input axi_len_t len,
                       input string tag);
    int n = 0;
    axi_if.arid    = id;
    axi_if.araddr  = addr;
    axi_if.arlen   = len;
    axi_if.arvalid = 1'b1;
    while (axi_if.arready !== 1'b1 && n < 32) begin
      cyc();
      n++;
    end
    if (n >= 32) check({tag, ".ar_timeout"}, 64'(axi_if.arready), 64'd1);
    cyc();
    axi_if.arvalid = 1'b0;
  endtask

  // Full write burst with data base+i; bad_beat flips wlast on that beat.
  task automatic do_write(input axi_id_t id, input axi_addr_t addr, input axi_len_t len,
                          input axi_data_t base, input axi_strb_t strb, input int bad_beat,
                          input axi_resp_t exp_resp, input string tag);
    do_aw(id, addr, len, tag);
    check({tag, ".wready_after_aw"}, 64'(axi_if.wready), 64'd1);
    check({tag, ".awready_busy"},    64'(axi_if.awready), 64'd0);
    for (int i = 0; i <= int'(len); i++) begin
      axi_if.wvalid = 1'b1;
      axi_if.wdata  = base + axi_data_t'(i);
      axi_if.wstrb  = strb;
      axi_if.wlast  = (i == int'(len)) ^ (i == bad_beat);
      cyc();
    end
    axi_if.wvalid = 1'b0;
    axi_if.wlast  = 1'b0;
    check({tag, ".bvalid"}, 64'(axi_if.bvalid), 64'd1);
    check({tag, ".bid"},    64'(axi_if.bid),    64'(id));
    check({tag, ".bresp"},  64'(axi_if.bresp),  64'(exp_resp));
    axi_if.bready = 1'b1;
    cyc();
    axi_if.bready = 1'b0;
    check({tag, ".bvalid_drop"},   64'(axi_if.bvalid),  64'd0);
    check({tag, ".awready_again"}, 64'(axi_if.awready), 64'd1);
  endtask

  // Read burst checked every cycle; toggle alternates rready 1,0,1,0...
  task automatic do_read(input axi_id_t id, input axi_addr_t addr, input axi_len_t len,
                         input axi_data_t ed [8], input axi_resp_t er [8], input bit toggle,
                         input string tag);
    int   hs = 0;
    int   n  = 0;
    logic rr = 1'b1;
    do_ar(id, addr, len, tag);
    while (hs <= int'(len) && hs < 8 && n < 64) begin
      axi_if.rready = toggle ? rr : 1'b1;
      check($sformatf("%s.rvalid[%0d]", tag, hs), 64'(axi_if.rvalid), 64'd1);
      check($sformatf("%s.rdata[%0d]",  tag, hs), 64'(axi_if.rdata),  64'(ed[hs]));
      check($sformatf("%s.rresp[%0d]",  tag, hs), 64'(axi_if.rresp),  64'(er[hs]));
      check($sformatf("%s.rid[%0d]",    tag, hs), 64'(axi_if.rid),    64'(id));
      check($sformatf("%s.rlast[%0d]",  tag, hs), 64'(axi_if.rlast),  64'(hs == int'(len)));
      if (axi_if.rready && axi_if.rvalid) hs++;
      rr = ~rr;
      cyc();
      n++;
    end
    axi_if.rready = 1'b0;
    check({tag, ".handshakes"},    64'(hs), 64'(int'(len) + 1));
    check({tag, ".rvalid_drop"},   64'(axi_if.rvalid),  64'd0);
    check({tag, ".arready_again"}, 64'(axi_if.arready), 64'd1);
  endtask

  initial begin
    rd_vec_t   vecs [10];
    axi_data_t ed [8];
    axi_resp_t er [8];

    axi_if.awid = '0;  axi_if.awaddr = '0; axi_if.awlen = '0; axi_if.awvalid = 1'b0;
    axi_if.wdata = '0; axi_if.wstrb = '0;  axi_if.wlast = 1'b0; axi_if.wvalid = 1'b0;
    axi_if.bready = 1'b0;
    axi_if.arid = '0;  axi_if.araddr = '0; axi_if.arlen = '0; axi_if.arvalid = 1'b0;
    axi_if.rready = 1'b0;

    vecs[0] = '{32'd2,          BASE,                       AXI_RESP_OKAY};
    vecs[1] = '{32'd9,          BASE + 64'd7,               AXI_RESP_OKAY};
    vecs[2] = '{32'd63,         64'haaaaaaaa89abcdef,       AXI_RESP_OKAY};
    vecs[3] = '{32'd64,         64'd0,                      AXI_RESP_SLVERR};
    vecs[4] = '{32'hffffffff,   64'd0,                      AXI_RESP_SLVERR};
    vecs[5] = '{32'd0,          64'h5555000000000001,       AXI_RESP_OKAY};
    vecs[6] = '{32'd20,         LDAT,                       AXI_RESP_OKAY};
    vecs[7] = '{32'd21,         LDAT + 64'd1,               AXI_RESP_OKAY};
    vecs[8] = '{32'd10,         CONC,                       AXI_RESP_OKAY};
    vecs[9] = '{32'd13,         CONC + 64'd3,               AXI_RESP_OKAY};

    // Reset state and release
    repeat (3) cyc();
    check_all_zero("reset");
    rst = 1'b0;
    check("reset.awready_before_edge", 64'(axi_if.awready), 64'd0);
    cyc();
    check("reset.awready_rise", 64'(axi_if.awready), 64'd1);
    check("reset.arready_rise", 64'(axi_if.arready), 64'd1);

    // Write burst addr 2, len 7
    do_write(4'd0, 32'd2, 8'd7, BASE, 8'hff, -1, AXI_RESP_OKAY, "wr_burst");

    // Read-back addr 3, len 7, continuous rready
    for (int i = 0; i < 8; i++) begin
      ed[i] = (i <= 6) ? BASE + axi_data_t'(i + 1) : 64'd0;
      er[i] = AXI_RESP_OKAY;
    end
    do_read(4'd1, 32'd3, 8'd7, ed, er, 1'b0, "readback");

    // Same read under rready 1010... backpressure
    do_read(4'd1, 32'd3, 8'd7, ed, er, 1'b1, "backpressure");

    // Full word at the top address, then partial strobe running off the end
    do_write(4'd2, 32'(DEPTH - 1), 8'd0, FULL, 8'hff, -1, AXI_RESP_OKAY,   "top_full");
    do_write(4'd3, 32'(DEPTH - 1), 8'd1, PART, 8'h0f, -1, AXI_RESP_SLVERR, "top_partial");

    // Early wlast flags the burst but data still lands
    do_write(4'd4, 32'd20, 8'd1, LDAT, 8'hff, 0, AXI_RESP_SLVERR, "early_wlast");

    // Address wrap: beat 0 out of range, beat 1 lands at word 0
    do_write(4'd5, 32'hffffffff, 8'd1, WRAP, 8'hff, -1, AXI_RESP_SLVERR, "wrap");

    // Concurrency: AW and AR to word 10 in the same cycle, lockstep beats
    check("conc.awready", 64'(axi_if.awready), 64'd1);
    check("conc.arready", 64'(axi_if.arready), 64'd1);
    axi_if.awid = 4'd3; axi_if.awaddr = 32'd10; axi_if.awlen = 8'd3; axi_if.awvalid = 1'b1;
    axi_if.arid = 4'd4; axi_if.araddr = 32'd10; axi_if.arlen = 8'd3; axi_if.arvalid = 1'b1;
    cyc();
    axi_if.awvalid = 1'b0;
    axi_if.arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      axi_if.wvalid = 1'b1;
      axi_if.wdata  = CONC + axi_data_t'(i);
      axi_if.wstrb  = 8'hff;
      axi_if.wlast  = (i == 3);
      axi_if.rready = 1'b1;
      check($sformatf("conc.wready[%0d]", i), 64'(axi_if.wready), 64'd1);
      check($sformatf("conc.rvalid[%0d]", i), 64'(axi_if.rvalid), 64'd1);
      check($sformatf("conc.rdata[%0d]", i),  64'(axi_if.rdata),  64'd0);
      check($sformatf("conc.rlast[%0d]", i),  64'(axi_if.rlast),  64'(i == 3));
      check($sformatf("conc.rid[%0d]", i),    64'(axi_if.rid),    64'd4);
      cyc();
    end
    axi_if.wvalid = 1'b0;
    axi_if.wlast  = 1'b0;
    axi_if.rready = 1'b0;
    check("conc.rvalid_drop", 64'(axi_if.rvalid), 64'd0);
    check("conc.bvalid",      64'(axi_if.bvalid), 64'd1);
    check("conc.bid",         64'(axi_if.bid),    64'd3);
    check("conc.bresp",       64'(axi_if.bresp),  64'(AXI_RESP_OKAY));
    axi_if.bready = 1'b1;
    cyc();
    axi_if.bready = 1'b0;

    // Single-beat read table
    for (int v = 0; v < 10; v++) begin
      ed[0] = vecs[v].data;
      er[0] = vecs[v].resp;
      do_read(4'd9, vecs[v].addr, 8'd0, ed, er, 1'b0, $sformatf("table%0d", v));
    end

    // AR lands while the write to the same word commits: next-cycle R sees it
    axi_if.awid = 4'd5; axi_if.awaddr = 32'd30; axi_if.awlen = 8'd0; axi_if.awvalid = 1'b1;
    cyc();
    axi_if.awvalid = 1'b0;
    check("fwd.wready",  64'(axi_if.wready),  64'd1);
    check("fwd.arready", 64'(axi_if.arready), 64'd1);
    axi_if.arid = 4'd6; axi_if.araddr = 32'd30; axi_if.arlen = 8'd0; axi_if.arvalid = 1'b1;
    axi_if.wvalid = 1'b1; axi_if.wdata = BYP; axi_if.wstrb = 8'hff; axi_if.wlast = 1'b1;
    cyc();
    axi_if.arvalid = 1'b0;
    axi_if.wvalid  = 1'b0;
    axi_if.wlast   = 1'b0;
    check("fwd.rvalid", 64'(axi_if.rvalid), 64'd1);
    check("fwd.rdata",  64'(axi_if.rdata),  64'(BYP));
    check("fwd.bvalid", 64'(axi_if.bvalid), 64'd1);
    axi_if.rready = 1'b1;
    axi_if.bready = 1'b1;
    cyc();
    axi_if.rready = 1'b0;
    axi_if.bready = 1'b0;

    // Reset after 3 of 8 write beats
    do_aw(4'd7, 32'd40, 8'd7, "mid_rst");
    for (int i = 0; i < 3; i++) begin
      axi_if.wvalid = 1'b1;
      axi_if.wdata  = BASE + axi_data_t'(i);
      axi_if.wstrb  = 8'hff;
      axi_if.wlast  = 1'b0;
      cyc();
    end
    axi_if.wvalid = 1'b0;
    rst = 1'b1;
    cyc();
    check_all_zero("mid_rst");
    rst = 1'b0;
    cyc();
    check("mid_rst.awready_rise", 64'(axi_if.awready), 64'd1);
    check("mid_rst.arready_rise", 64'(axi_if.arready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mid_rst.no_bvalid[%0d]", i), 64'(axi_if.bvalid), 64'd0);
      cyc();
    end
    ed[0] = 64'd0;
    er[0] = AXI_RESP_OKAY;
    do_read(4'd1, 32'd40, 8'd0, ed, er, 1'b0, "post_rst40");
    do_read(4'd1, 32'd2,  8'd0, ed, er, 1'b0, "post_rst2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
